uart_rx_seq: RTL and testbench

Receive-side sequencer for the serial debug unit's UART link. It synchronises the raw `rxd` line, qualifies a start bit at mid-bit, samples eight data bits LSB-first and the stop bit at bit centres, and delivers one byte with a single-cycle `vld_rx` strobe. It sits between the pad-level `rxd` input and the command parser. `vld_rx` is also the strobe the front-end start detector uses to re-arm.

---
 rtl/uart_rx_seq_if.sv | 18 +
 rtl/uart_rx_seq.sv | 115 +++++++++++
 tb/tb_uart_rx_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_seq_if
// Purpose  : Serial line in, received byte and status strobes out.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_seq_if;
    logic       rxd;
    logic [7:0] dout;
    logic       vld_rx;
    logic       frm_err;
    logic       busy;

    // master: the receiver itself; slave: the byte consumer / line driver
    modport master (input rxd, output dout, vld_rx, frm_err, busy);
    modport slave  (output rxd, input dout, vld_rx, frm_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_seq
// Purpose  : UART receive sequencer - mid-bit start qualification, 8N1 capture.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_seq #(
    parameter int BIT_TICKS = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_rx_seq_if.master bus
);
    localparam int HALF    = BIT_TICKS / 2;
    localparam int c_cnt_w = $clog2(BIT_TICKS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIT_TICKS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_sh;
    logic                 r_s1;
    logic                 r_rxd_s;
    logic [7:0]           r_dout;
    logic                 r_vld_rx;
    logic                 r_frm_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            r_s1      <= 1'b1;
            r_rxd_s   <= 1'b1;
            r_dout    <= '0;
            r_vld_rx  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_s1      <= bus.rxd;
            r_rxd_s   <= r_s1;
            r_vld_rx  <= 1'b0;
            r_frm_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    // a high line anywhere in the first half bit is a glitch
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_cnt_half) begin
                        r_state   <= S_DATA;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_cnt_last) begin
                        r_sh      <= {r_rxd_s, r_sh[7:1]};
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_cnt_last) begin
                        if (r_rxd_s) begin
                            r_dout   <= r_sh;
                            r_vld_rx <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_frm_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // wait out a held-low line before hunting for a new start
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dout    = r_dout;
    assign bus.vld_rx  = r_vld_rx;
    assign bus.frm_err = r_frm_err;
    assign bus.busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_seq
// Purpose  : Directed frames against a frame-timing scoreboard, two BIT_TICKS.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_seq_if bus16();
    uart_rx_seq_if bus4();

    uart_rx_seq #(.BIT_TICKS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master));
    uart_rx_seq #(.BIT_TICKS(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: per instance, scheduled output strobes and busy windows (cycle numbers)
    int         ev_cyc  [2][32];
    int         ev_kind [2][32];   // 0 = byte delivered, 1 = framing error
    logic [7:0] ev_byte [2][32];
    int         ev_hd   [2];
    int         ev_tl   [2];
    int         win_lo  [2][32];
    int         win_hi  [2][32];
    int         win_n   [2];
    logic [7:0] m_dout  [2];
    int         n_vld   [2];
    int         n_ferr  [2];
    int         last_vld[2];
    int         prev_vld[2];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic void chk(string name, int k, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endfunction

    function automatic void chk_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void push_win(int k, int lo, int hi);
        win_lo[k][win_n[k]] = lo;
        win_hi[k][win_n[k]] = hi;
        win_n[k]++;
    endfunction

    function automatic void push_ev(int k, int c, int kind, logic [7:0] b);
        ev_cyc[k][ev_tl[k]]  = c;
        ev_kind[k][ev_tl[k]] = kind;
        ev_byte[k][ev_tl[k]] = b;
        ev_tl[k]++;
    endfunction

    task automatic compare_cycle();
        logic       e_v, e_f, e_b, a_v, a_f, a_b;
        logic [7:0] a_d;
        for (int k = 0; k < 2; k++) begin
            e_v = 1'b0; e_f = 1'b0; e_b = 1'b0;
            a_d = (k == 0) ? bus16.dout    : bus4.dout;
            a_v = (k == 0) ? bus16.vld_rx  : bus4.vld_rx;
            a_f = (k == 0) ? bus16.frm_err : bus4.frm_err;
            a_b = (k == 0) ? bus16.busy    : bus4.busy;
            if (rst) begin
                ev_hd[k] = ev_tl[k];
                win_n[k] = 0;
                m_dout[k] = 8'h00;
            end else begin
                if (ev_hd[k] != ev_tl[k] && ev_cyc[k][ev_hd[k]] == cyc) begin
                    if (ev_kind[k][ev_hd[k]] == 0) begin
                        e_v = 1'b1;
                        m_dout[k] = ev_byte[k][ev_hd[k]];
                    end else begin
                        e_f = 1'b1;
                    end
                    ev_hd[k]++;
                end
                for (int w = 0; w < win_n[k]; w++)
                    if (cyc >= win_lo[k][w] && cyc <= win_hi[k][w]) e_b = 1'b1;
            end
            chk("dout",    k, a_d, m_dout[k]);
            chk("vld_rx",  k, {7'd0, a_v}, {7'd0, e_v});
            chk("frm_err", k, {7'd0, a_f}, {7'd0, e_f});
            chk("busy",    k, {7'd0, a_b}, {7'd0, e_b});
            if (a_v) begin
                n_vld[k]++;
                prev_vld[k] = last_vld[k];
                last_vld[k] = cyc;
            end
            if (a_f) n_ferr[k]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic set_rxd(int k, logic v);
        if (k == 0) bus16.rxd = v;
        else        bus4.rxd  = v;
    endtask

    task automatic idle(int k, int n);
        set_rxd(k, 1'b1);
        repeat (n) tick();
    endtask

    // Frame timing: edge e1 first sees the start bit; the stop-bit outcome shows
    // at cycle e1+2+HALF+9*BT. cut>0 aborts after that many driven cycles.
    task automatic send_frame(input int k, input logic [7:0] b, input logic stop,
                              input int extra_low_bits, input int cut, output int e1);
        int         bt, half, sc, n;
        logic [9:0] bits;
        bt   = (k == 0) ? 16 : 4;
        half = bt / 2;
        e1   = cyc + 1;
        sc   = e1 + 2 + half + 9 * bt;
        n    = 0;
        bits = {stop, b, 1'b0};
        push_win(k, e1 + 2, stop ? sc - 1 : e1 + (10 + extra_low_bits) * bt + 1);
        push_ev(k, sc, stop ? 0 : 1, b);
        for (int i = 0; i < 10; i++) begin
            set_rxd(k, bits[i]);
            for (int c = 0; c < bt; c++) begin
                if (cut > 0 && n == cut) return;
                tick();
                n++;
            end
        end
        if (!stop) begin
            set_rxd(k, 1'b0);
            repeat (extra_low_bits * bt) tick();
        end
        set_rxd(k, 1'b1);
    endtask

    // n-cycle low pulse: busy while the synchronised low is seen in START
    task automatic glitch(int k, int n);
        int e1;
        e1 = cyc + 1;
        push_win(k, e1 + 2, e1 + n + 1);
        set_rxd(k, 1'b0);
        repeat (n) tick();
        set_rxd(k, 1'b1);
    endtask

    initial begin
        int e1, v0, f0;
        for (int k = 0; k < 2; k++) begin
            ev_hd[k] = 0; ev_tl[k] = 0; win_n[k] = 0; m_dout[k] = 8'h00;
            n_vld[k] = 0; n_ferr[k] = 0; last_vld[k] = 0; prev_vld[k] = 0;
        end
        bus16.rxd = 1'b1;
        bus4.rxd  = 1'b1;

        repeat (3) tick();
        #2 rst = 1'b0;
        idle(0, 20);

        // single frame 0xA5
        v0 = n_vld[0]; f0 = n_ferr[0];
        send_frame(0, 8'hA5, 1'b1, 0, 0, e1);
        idle(0, 40);
        chk_int("a5_vld_edge", last_vld[0] - e1, 154);
        chk_int("a5_vld_count", n_vld[0] - v0, 1);
        chk_int("a5_ferr_count", n_ferr[0] - f0, 0);
        chk("a5_dout", 0, bus16.dout, 8'hA5);

        // 5-cycle glitch
        v0 = n_vld[0]; f0 = n_ferr[0];
        glitch(0, 5);
        idle(0, 30);
        chk_int("glitch_vld_count", n_vld[0] - v0, 0);
        chk_int("glitch_ferr_count", n_ferr[0] - f0, 0);
        chk("glitch_dout", 0, bus16.dout, 8'hA5);

        // framing error on 0x3C, line held low 3 bit times, then 0x55
        v0 = n_vld[0]; f0 = n_ferr[0];
        send_frame(0, 8'h3C, 1'b0, 3, 0, e1);
        idle(0, 40);
        chk_int("ferr_count", n_ferr[0] - f0, 1);
        chk_int("ferr_vld_count", n_vld[0] - v0, 0);
        chk("ferr_dout_hold", 0, bus16.dout, 8'hA5);
        send_frame(0, 8'h55, 1'b1, 0, 0, e1);
        idle(0, 40);
        chk("recover_dout", 0, bus16.dout, 8'h55);

        // back-to-back 0x00 then 0xFF
        v0 = n_vld[0];
        send_frame(0, 8'h00, 1'b1, 0, 0, e1);
        send_frame(0, 8'hFF, 1'b1, 0, 0, e1);
        idle(0, 40);
        chk_int("b2b_vld_count", n_vld[0] - v0, 2);
        chk_int("b2b_spacing", last_vld[0] - prev_vld[0], 160);
        chk("b2b_dout", 0, bus16.dout, 8'hFF);

        // reset in the middle of data bit 4 of 0x81
        send_frame(0, 8'h81, 1'b1, 0, 5 * 16 + 8, e1);
        chk("pre_reset_busy", 0, {7'd0, bus16.busy}, 8'h01);
        #2 rst = 1'b1;
        bus16.rxd = 1'b1;
        #1;
        chk("async_dout", 0, bus16.dout, 8'h00);
        chk("async_busy", 0, {7'd0, bus16.busy}, 8'h00);
        chk("async_vld", 0, {7'd0, bus16.vld_rx}, 8'h00);
        chk("async_ferr", 0, {7'd0, bus16.frm_err}, 8'h00);
        repeat (3) tick();
        #2 rst = 1'b0;
        idle(0, 32);
        send_frame(0, 8'h81, 1'b1, 0, 0, e1);
        idle(0, 40);
        chk("post_reset_dout", 0, bus16.dout, 8'h81);

        // BIT_TICKS=4 instance, frame 0x5A
        idle(1, 8);
        send_frame(1, 8'h5A, 1'b1, 0, 0, e1);
        idle(1, 12);
        chk_int("bt4_vld_edge", last_vld[1] - e1, 40);
        chk("bt4_dout", 1, bus4.dout, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
